sensor_pulse_gen: RTL and testbench

Programmable encoder-pulse emulator for the motor speed/position path. It drives the two wheel-sensor lines with a pulse train of a commanded half-period and pulse count. The position counters and clock counter can then be exercised in loopback, on the board or in simulation, without motors attached. It sits on the sensor side of the position-counting interface and feeds the same lines the position manager samples.

---
 rtl/sensor_pulse_gen.sv | 130 +++++++++++++
 tb/tb_sensor_pulse_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_pulse_gen.sv
// Encoder-pulse emulator: drives the two wheel-sensor lines with a train of
// equal high/low phases, counting falling edges, for loopback of the position path.
module sensor_pulse_gen #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [COUNT_W-1:0]  n_pulses,
    input  logic [1:0]          ch_en,
    output logic                m1,
    output logic                m2,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  pulses_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t              r_state;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_phase_cnt;
    logic [COUNT_W-1:0]  r_n;
    logic [COUNT_W-1:0]  r_sent;
    logic [1:0]          r_en;
    logic                r_m1;
    logic                r_m2;
    logic                r_busy;
    logic                r_done;

    logic [PERIOD_W-1:0] w_p;
    logic                w_phase_last;
    logic                w_train_end;

    // A zero half-period behaves as one cycle so the phase counter never underflows.
    assign w_p          = (half_period == {PERIOD_W{1'b0}}) ? PERIOD_W'(1) : half_period;
    assign w_phase_last = (r_phase_cnt == PERIOD_W'(1));
    assign w_train_end  = (r_n != {COUNT_W{1'b0}}) && (r_sent == r_n);

    // Train sequencer with registered sensor lines, busy, done and edge count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_period    <= {PERIOD_W{1'b0}};
            r_phase_cnt <= {PERIOD_W{1'b0}};
            r_n         <= {COUNT_W{1'b0}};
            r_sent      <= {COUNT_W{1'b0}};
            r_en        <= 2'b00;
            r_m1        <= 1'b0;
            r_m2        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_period    <= w_p;
                        r_phase_cnt <= w_p;
                        r_n         <= n_pulses;
                        r_en        <= ch_en;
                        r_sent      <= {COUNT_W{1'b0}};
                        r_m1        <= ch_en[0];
                        r_m2        <= ch_en[1];
                        r_busy      <= 1'b1;
                        r_state     <= ST_HIGH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (stop) begin
                        r_m1    <= 1'b0;
                        r_m2    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_phase_last) begin
                        // The count steps on the same edge that drops the lines.
                        r_sent      <= r_sent + COUNT_W'(1);
                        r_phase_cnt <= r_period;
                        r_m1        <= 1'b0;
                        r_m2        <= 1'b0;
                        r_state     <= ST_LOW;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - PERIOD_W'(1);
                    end
                end
                ST_LOW: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_phase_last) begin
                        if (w_train_end) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_phase_cnt <= r_period;
                            r_m1        <= r_en[0];
                            r_m2        <= r_en[1];
                            r_state     <= ST_HIGH;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt - PERIOD_W'(1);
                    end
                end
                default: begin
                    r_m1    <= 1'b0;
                    r_m2    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m1          = r_m1;
    assign m2          = r_m2;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pulses_sent = r_sent;

endmodule

// File: tb/tb_sensor_pulse_gen.sv
// Bench for sensor_pulse_gen: an elapsed-time model of the pulse train checked
// every cycle, plus directed scenarios with literal busy/edge/count expectations.
module tb_sensor_pulse_gen;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] half_period = 16'd0;
    logic [15:0] n_pulses = 16'd0;
    logic [1:0]  ch_en = 2'b00;
    logic        m1, m2, busy, done;
    logic [15:0] pulses_sent;

    int n_cmp = 0;
    int n_err = 0;

    sensor_pulse_gen #(.PERIOD_W(16), .COUNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .half_period(half_period), .n_pulses(n_pulses), .ch_en(ch_en),
        .m1(m1), .m2(m2), .busy(busy), .done(done), .pulses_sent(pulses_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a train is described by its start time and operands; outputs follow
    // from the number of cycles elapsed since the accepting edge.
    bit          mdl_active = 1'b0;
    bit          mdl_done = 1'b0;
    longint      mdl_t, mdl_p, mdl_n;
    logic [1:0]  mdl_en;
    logic [15:0] mdl_sent_idle = 16'd0;

    initial begin
        longint      phase;
        logic        e_m1, e_m2, e_busy, e_done;
        logic [15:0] e_sent;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mdl_active    = 1'b0;
                mdl_done      = 1'b0;
                mdl_sent_idle = 16'd0;
            end
            if (mdl_active) begin
                phase  = mdl_t / mdl_p;
                e_m1   = (phase % 2 == 0) && mdl_en[0];
                e_m2   = (phase % 2 == 0) && mdl_en[1];
                e_busy = 1'b1;
                e_done = 1'b0;
                e_sent = 16'((phase + 1) / 2);
            end else begin
                e_m1   = 1'b0;
                e_m2   = 1'b0;
                e_busy = 1'b0;
                e_done = mdl_done;
                e_sent = mdl_sent_idle;
            end
            chk("m1", m1, e_m1);
            chk("m2", m2, e_m2);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("pulses_sent", pulses_sent, e_sent);
            if (resetn) begin
                if (mdl_active) begin
                    if (stop) begin
                        mdl_active    = 1'b0;
                        mdl_sent_idle = e_sent;
                    end else if (mdl_n != 0 && mdl_t + 1 == 2 * mdl_p * mdl_n) begin
                        mdl_active    = 1'b0;
                        mdl_done      = 1'b1;
                        mdl_sent_idle = 16'(mdl_n);
                    end else begin
                        mdl_t++;
                    end
                end else begin
                    mdl_done = 1'b0;
                    if (start && !stop) begin
                        mdl_active = 1'b1;
                        mdl_t      = 0;
                        mdl_p      = (half_period == 16'd0) ? 1 : longint'(half_period);
                        mdl_n      = longint'(n_pulses);
                        mdl_en     = ch_en;
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [15:0] hp, input logic [15:0] np, input logic [1:0] en);
        @(posedge clk); #1;
        half_period = hp; n_pulses = np; ch_en = en; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after the accepting edge; returns at the first idle cycle.
    task automatic wait_train(input string nm, input int exp_busy, input int exp_r1,
                              input int exp_r2, input int exp_sent);
        int   bc = 0, r1 = 0, r2 = 0;
        logic p1 = 1'b0, p2 = 1'b0;
        bit   ended = 1'b0;
        for (int i = 0; i < 5000 && !ended; i++) begin
            @(negedge clk);
            if (busy) begin
                bc++;
                if (m1 && !p1) r1++;
                if (m2 && !p2) r2++;
                p1 = m1;
                p2 = m2;
            end else begin
                ended = 1'b1;
            end
        end
        chk({nm, "_ended"}, 32'(ended), 32'd1);
        chk({nm, "_busy_cycles"}, bc, exp_busy);
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_m1_rises"}, r1, exp_r1);
        chk({nm, "_m2_rises"}, r2, exp_r2);
        chk({nm, "_sent"}, 32'(pulses_sent), exp_sent);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_m1", 32'(m1), 32'd0);
        chk("rst_m2", 32'(m2), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sent", 32'(pulses_sent), 32'd0);

        pulse_start(16'd3, 16'd4, 2'b11);
        wait_train("basic", 24, 4, 4, 4);

        pulse_start(16'd0, 16'd2, 2'b11);
        wait_train("degen", 4, 2, 2, 2);

        pulse_start(16'd2, 16'd3, 2'b01);
        wait_train("mask", 12, 3, 0, 3);

        pulse_start(16'd1, 16'd2, 2'b00);
        wait_train("no_ch", 4, 0, 0, 2);

        // Continuous mode, stop sampled at the edge ending the tenth busy cycle.
        pulse_start(16'd1, 16'd0, 2'b11);
        repeat (9) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_m1", 32'(m1), 32'd0);
        chk("abort_m2", 32'(m2), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sent", 32'(pulses_sent), 32'd5);
        repeat (4) @(posedge clk);

        // Second start and operand changes mid-train must not disturb it.
        pulse_start(16'd2, 16'd2, 2'b11);
        fork
            wait_train("restart", 8, 2, 2, 2);
            begin
                repeat (3) @(posedge clk);
                #1 start = 1'b1; half_period = 16'd7; n_pulses = 16'd9; ch_en = 2'b00;
                @(posedge clk); #1 start = 1'b0;
            end
        join

        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", 32'(busy), 32'd0);

        // Start sampled in the done cycle begins the next train immediately.
        pulse_start(16'd2, 16'd1, 2'b11);
        repeat (4) @(posedge clk);
        #1 chk("b2b_done", 32'(done), 32'd1);
        half_period = 16'd1; n_pulses = 16'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_clr", 32'(done), 32'd0);
        wait_train("b2b", 2, 1, 1, 1);

        // Asynchronous reset in the middle of a high phase.
        pulse_start(16'd5, 16'd2, 2'b11);
        @(posedge clk); #1;
        chk("pre_rst_m1", 32'(m1), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_m1", 32'(m1), 32'd0);
        chk("arst_m2", 32'(m2), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
